// File: rtl/aes_invcipher_multikey_pkg.sv
// Shared types, round counts and the AES inverse-round leaf functions.
// The inverse S-box is computed arithmetically: inverse affine map, then GF(2^8) inversion.
package aes_invcipher_multikey_pkg;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        KL128 = 2'd0,
        KL192 = 2'd1,
        KL256 = 2'd2,
        KLBAD = 2'd3
    } key_len_e;

    typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} fsm_e;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    function automatic logic [3:0] nr_of(input key_len_e kl);
        case (kl)
            KL192:   return NR_192;
            KL256:   return NR_256;
            default: return NR_128;
        endcase
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] a;
        logic [7:0] sq;
        logic [7:0] inv;
        a   = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv;
    endfunction

    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
        return o;
    endfunction

    function automatic aes_state_t inv_sub_bytes(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic aes_state_t inv_mix_columns(input aes_state_t s);
        aes_state_t o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_invcipher_multikey_if.sv
// Ciphertext/plaintext handshakes plus the round-key lookup into the key-schedule store.
interface aes_invcipher_multikey_if;
    import aes_invcipher_multikey_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t in_data;
    logic [1:0] key_len;
    logic [3:0] rk_idx;
    aes_state_t rk_data;
    logic       out_valid;
    logic       out_ready;
    aes_state_t out_data;

    modport master (
        output in_valid, in_data, key_len, rk_data, out_ready,
        input  in_ready, rk_idx, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, key_len, rk_data, out_ready,
        output in_ready, rk_idx, out_valid, out_data
    );
endinterface

// File: rtl/aes_invcipher_multikey_invround.sv
// One combinational AES inverse round; the final round skips InvMixColumns.
module aes_invcipher_multikey_invround
    import aes_invcipher_multikey_pkg::*;
(
    input  aes_state_t state,
    input  aes_state_t rk,
    input  logic       last,
    output aes_state_t result
);
    aes_state_t keyed;

    assign keyed  = inv_sub_bytes(inv_shift_rows(state)) ^ rk;
    assign result = last ? keyed : inv_mix_columns(keyed);
endmodule

// File: rtl/aes_invcipher_multikey.sv
// Iterative AES-128/192/256 inverse cipher, one round per clock, round keys fetched by index.
module aes_invcipher_multikey
    import aes_invcipher_multikey_pkg::*;
#(
    parameter bit SUPPORT_192 = 1'b1,
    parameter bit SUPPORT_256 = 1'b1
) (
    input  logic clk,
    input  logic reset,
    aes_invcipher_multikey_if.slave bus,
    output logic busy,
    output logic mode_err
);
    fsm_e       fsm;
    logic [3:0] ctr;
    logic [3:0] nr_in;
    logic [3:0] rk_idx;
    aes_state_t stm;
    aes_state_t round_out;
    aes_state_t out_data;
    logic       out_valid;
    logic       in_ready;
    logic       accept;
    logic       bad_len;
    key_len_e   kl;
    key_len_e   kl_eff;

    // Illegal or disabled key lengths fall back to AES-128 and are flagged
    always_comb begin
        kl      = key_len_e'(bus.key_len);
        kl_eff  = kl;
        bad_len = 1'b0;
        case (kl)
            KL192: if (!SUPPORT_192) begin kl_eff = KL128; bad_len = 1'b1; end
            KL256: if (!SUPPORT_256) begin kl_eff = KL128; bad_len = 1'b1; end
            KLBAD: begin kl_eff = KL128; bad_len = 1'b1; end
            default: ;
        endcase
    end

    assign nr_in    = nr_of(kl_eff);
    assign in_ready = reset && ((fsm == IDLE) || ((fsm == DONE) && bus.out_ready));
    assign accept   = bus.in_valid && in_ready;
    assign mode_err = accept && bad_len;
    assign busy     = (fsm == RUN) || (fsm == LAST);

    always_comb begin
        rk_idx = 4'd0;
        case (fsm)
            IDLE:    rk_idx = nr_in;
            RUN:     rk_idx = ctr;
            DONE:    if (accept) rk_idx = nr_in;
            default: rk_idx = 4'd0;
        endcase
    end

    aes_invcipher_multikey_invround u_round (
        .state  (stm),
        .rk     (bus.rk_data),
        .last   (fsm == LAST),
        .result (round_out)
    );

    // A block accepted in DONE starts its rounds while the previous result is being taken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm       <= IDLE;
            ctr       <= 4'd0;
            stm       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (accept) begin
                        stm <= bus.in_data ^ bus.rk_data;
                        ctr <= nr_in - 4'd1;
                        fsm <= RUN;
                    end
                end
                RUN: begin
                    stm <= round_out;
                    if (ctr != 4'd0) ctr <= ctr - 4'd1;
                    if (ctr <= 4'd1) fsm <= LAST;
                end
                LAST: begin
                    out_data  <= round_out;
                    out_valid <= 1'b1;
                    fsm       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            stm <= bus.in_data ^ bus.rk_data;
                            ctr <= nr_in - 4'd1;
                            fsm <= RUN;
                        end else begin
                            fsm <= IDLE;
                        end
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.rk_idx    = rk_idx;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
endmodule

// File: tb/tb_aes_invcipher_multikey.sv
// Bench for aes_invcipher_multikey: FIPS-197 vectors plus random blocks encrypted by a forward-cipher model.
module tb_aes_invcipher_multikey;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic mode_err;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rk_mem [16];

    localparam logic [255:0] C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] C2_KEY = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C2_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;

    aes_invcipher_multikey_if bus ();

    aes_invcipher_multikey dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .mode_err (mode_err)
    );

    always #5 clk = ~clk;

    assign bus.rk_data = rk_mem[bus.rk_idx];

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b} << k;
        return d[15:8];
    endfunction

    // Forward S-box from exp/log tables over generator 3, then the forward affine map
    task automatic build_sbox();
        logic [7:0] e [256];
        int         lg [256];
        logic [7:0] v;
        logic [7:0] inv;
        v = 8'h01;
        for (int i = 0; i < 255; i++) begin
            e[i]  = v;
            lg[v] = i;
            v     = v ^ xtime(v);
        end
        for (int x = 0; x < 256; x++) begin
            inv     = (x == 0) ? 8'h00 : e[(255 - lg[x]) % 255];
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic load_keys(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk_mem[r] = '0;
        end
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [127:0] s, t;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ rk_mem[0];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = t[127-8*((i%4)+4*(((i/4)+(i%4))%4)) -: 8];
            if (r < nr) begin
                t = s;
                for (int c = 0; c < 4; c++) begin
                    a0 = t[127-32*c -: 8];
                    a1 = t[119-32*c -: 8];
                    a2 = t[111-32*c -: 8];
                    a3 = t[103-32*c -: 8];
                    s[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                    s[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                    s[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                    s[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
                end
            end
            s = s ^ rk_mem[r];
        end
        return s;
    endfunction

    // Presents one block for a single accept cycle, then scrambles key_len to show it is not resampled
    task automatic applyStimulus(input logic [1:0] kl, input logic [127:0] ct, input int nr, input logic err);
        bus.in_valid = 1'b1;
        bus.in_data  = ct;
        bus.key_len  = kl;
        #1;
        checkOutput("in_ready_accept", bus.in_ready, 1'b1);
        checkOutput("rk_idx_accept", bus.rk_idx, nr);
        checkOutput("mode_err_accept", mode_err, err);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.key_len  = 2'($urandom);
        bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
        checkOutput("busy_run", busy, 1'b1);
        checkOutput("mode_err_pulse", mode_err, 1'b0);
    endtask

    task automatic waitResult(input int nr, input logic [127:0] pt, input bit noise);
        int cyc;
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            checkOutput("rk_idx_round", bus.rk_idx, (cyc < nr - 1) ? nr - 1 - cyc : 0);
            checkOutput("in_ready_busy", bus.in_ready, 1'b0);
            bus.in_valid = noise ? 1'($urandom) : 1'b0;
            bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        checkOutput("latency", cyc, nr);
        checkOutput("plaintext", bus.out_data, pt);
        checkOutput("busy_done", busy, 1'b0);
    endtask

    task automatic runBlock(input logic [1:0] kl, input logic [127:0] ct, input logic [127:0] pt,
                            input int nr, input logic err, input bit noise);
        applyStimulus(kl, ct, nr, err);
        waitResult(nr, pt, noise);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("out_valid_clear", bus.out_valid, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [255:0] key;
        logic [127:0] pt;
        logic [1:0]   kl;
        int           nk;

        build_sbox();
        load_keys(C1_KEY, 4);
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.key_len   = 2'd0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", bus.in_ready, 1'b0);
        checkOutput("rst_out_valid", bus.out_valid, 1'b0);
        checkOutput("rst_out_data", bus.out_data, '0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_mode_err", mode_err, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("in_ready_after_rst", bus.in_ready, 1'b1);
        @(posedge clk); #1;

        $display("[TB] FIPS-197 C.1 / C.2 / C.3");
        load_keys(C1_KEY, 4); runBlock(2'd0, C1_CT, PT, 10, 1'b0, 1'b0);
        load_keys(C2_KEY, 6); runBlock(2'd1, C2_CT, PT, 12, 1'b0, 1'b0);
        load_keys(C3_KEY, 8); runBlock(2'd2, C3_CT, PT, 14, 1'b0, 1'b0);

        $display("[TB] illegal key_len");
        load_keys(C1_KEY, 4); runBlock(2'd3, C1_CT, PT, 10, 1'b1, 1'b1);

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(2'd0, C1_CT, 10, 1'b0);
        waitResult(10, PT, 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
            checkOutput("bp_out_valid", bus.out_valid, 1'b1);
            checkOutput("bp_out_data", bus.out_data, PT);
            checkOutput("bp_in_ready", bus.in_ready, 1'b0);
            checkOutput("bp_busy", busy, 1'b0);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp_in_ready_release", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        checkOutput("bp_out_valid_clear", bus.out_valid, 1'b0);

        $display("[TB] back-to-back");
        bus.out_ready = 1'b0;
        applyStimulus(2'd0, C1_CT, 10, 1'b0);
        waitResult(10, PT, 1'b0);
        load_keys(C3_KEY, 8);
        bus.out_ready = 1'b1;
        applyStimulus(2'd2, C3_CT, 14, 1'b0);
        checkOutput("b2b_first_taken", bus.out_valid, 1'b0);
        waitResult(14, PT, 1'b1);
        @(posedge clk); #1;
        checkOutput("b2b_out_valid_clear", bus.out_valid, 1'b0);

        $display("[TB] reset during round 5");
        load_keys(C1_KEY, 4);
        applyStimulus(2'd0, C1_CT, 10, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        checkOutput("midrst_out_valid", bus.out_valid, 1'b0);
        checkOutput("midrst_out_data", bus.out_data, '0);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_in_ready", bus.in_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        checkOutput("midrst_no_output", bus.out_valid, 1'b0);
        runBlock(2'd0, C1_CT, PT, 10, 1'b0, 1'b0);

        $display("[TB] random blocks");
        for (int n = 0; n < 10; n++) begin
            kl  = 2'($urandom_range(0, 3));
            nk  = (kl == 2'd1) ? 6 : (kl == 2'd2) ? 8 : 4;
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            load_keys(key, nk);
            runBlock(kl, encrypt(pt, nk + 6), pt, nk + 6, kl == 2'd3, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
